// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  localparam logic [3:0] DIG_OVF    = 4'hE;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Largest value representable in ndig decimal digits (10^ndig - 1).
  function automatic logic [63:0] maxDisp(input int ndig);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < ndig; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 adjust every nibble >= 5, then shift in one bit.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic [4*NDIG-1:0] acc,
  input  logic              bitIn,
  output logic [4*NDIG-1:0] accNext
);

  localparam int ACC_W = 4 * NDIG;

  logic [ACC_W-1:0] adj;

  always_comb begin
    adj = acc;
    for (int i = 0; i < NDIG; i++) begin
      if (acc[4*i +: 4] >= ADJ_THRESH) adj[4*i +: 4] = acc[4*i +: 4] + ADJ_ADD;
    end
    // Carry out of the top nibble is dropped; overflow is flagged separately.
    accNext = (adj << 1) | ACC_W'(bitIn);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, registered digit outputs.
// Optional leading-zero blanking mask is enabled by defining BCD_LZB_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int NDIG = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSTART,
  input  logic [IN_W-1:0]   iBIN,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [4*NDIG-1:0] oDIG,
  output logic              oOVF,
  output logic [NDIG-1:0]   oBLANK
);

  localparam int ACC_W = 4 * NDIG;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [63:0] MAX_VAL = maxDisp(NDIG);

  state_t           state, stateNext;
  logic [IN_W-1:0]  shReg;
  logic [ACC_W-1:0] acc, accStep;
  logic [CNT_W-1:0] cnt;
  logic             ovfPend;

  bcd_dabble_step #(.NDIG(NDIG)) uStep (
    .acc    (acc),
    .bitIn  (shReg[IN_W-1]),
    .accNext(accStep)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iSTART) stateNext = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) stateNext = LOAD;
      LOAD:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign oBUSY = (state != IDLE);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      shReg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovfPend <= 1'b0;
      oDONE   <= 1'b0;
      oDIG    <= '0;
      oOVF    <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iSTART) begin
            shReg   <= iBIN;
            acc     <= '0;
            cnt     <= CNT_W'(IN_W);
            ovfPend <= (64'(iBIN) > MAX_VAL);
          end
        end
        SHIFT: begin
          acc   <= accStep;
          shReg <= shReg << 1;
          cnt   <= cnt - CNT_W'(1);
        end
        LOAD: begin
          oDONE <= 1'b1;
          oOVF  <= ovfPend;
          oDIG  <= ovfPend ? {NDIG{DIG_OVF}} : acc;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_LZB_EN
  logic [NDIG-1:0] blankNext;

  // Digit i blanks only when it and every more significant digit are zero.
  always_comb begin
    logic allZero;
    allZero   = 1'b1;
    blankNext = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      allZero      = allZero & (acc[4*i +: 4] == 4'd0);
      blankNext[i] = allZero;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N)            oBLANK <= {{(NDIG-1){1'b1}}, 1'b0};
    else if (state == LOAD) oBLANK <= ovfPend ? '0 : blankNext;
  end
`else
  assign oBLANK = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random values against a decimal model.
module tb_bin2bcd_seq;

  localparam int IN_W = 16;
  localparam int NDIG = 4;
  localparam int LAT  = IN_W + 1;

  logic              iCLK = 1'b0;
  logic              iRST_N = 1'b0;
  logic              iSTART = 1'b0;
  logic [IN_W-1:0]   iBIN = '0;
  logic              oBUSY, oDONE, oOVF;
  logic [4*NDIG-1:0] oDIG;
  logic [NDIG-1:0]   oBLANK;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.IN_W(IN_W), .NDIG(NDIG)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iSTART(iSTART),
    .iBIN  (iBIN),
    .oBUSY (oBUSY),
    .oDONE (oDONE),
    .oDIG  (oDIG),
    .oOVF  (oOVF),
    .oBLANK(oBLANK)
  );

  always #5 iCLK = ~iCLK;

  // Decimal reference: digits from division, overflow above 10^NDIG-1.
  function automatic logic [15:0] modelDig(input int unsigned v);
    logic [15:0] r;
    int unsigned p;
    if (v > 9999) return 16'hEEEE;
    r = '0;
    p = 1;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i (i >= 1) is blank exactly when the value is below 10^i.
  function automatic logic [3:0] modelBlank(input int unsigned v);
    logic [3:0] b;
    int unsigned p;
    b = '0;
`ifdef BCD_LZB_EN
    if (v <= 9999) begin
      p = 10;
      for (int i = 1; i < NDIG; i++) begin
        b[i] = (v < p);
        p = p * 10;
      end
    end
`else
    p = 0;
`endif
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge; iBIN is scrambled afterwards to show it is not re-sampled.
  task automatic launch(input int unsigned v);
    iBIN   = IN_W'(v);
    iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    iBIN   = IN_W'($urandom);
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge iCLK); #1;
      if (oDONE) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input int unsigned v);
    check({tag, "_dig"}, 32'(oDIG), 32'(modelDig(v)));
    check({tag, "_ovf"}, 32'(oOVF), 32'(v > 9999));
    check({tag, "_blank"}, 32'(oBLANK), 32'(modelBlank(v)));
    check({tag, "_busy"}, 32'(oBUSY), 32'd0);
  endtask

  task automatic runConv(input string tag, input int unsigned v);
    int lat;
    launch(v);
    check({tag, "_busyrun"}, 32'(oBUSY), 32'd1);
    waitDone(lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    checkResult(tag, v);
    @(posedge iCLK); #1;
    check({tag, "_donepulse"}, 32'(oDONE), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_dig"}, 32'(oDIG), 32'd0);
    check({tag, "_busy"}, 32'(oBUSY), 32'd0);
    check({tag, "_done"}, 32'(oDONE), 32'd0);
    check({tag, "_ovf"}, 32'(oOVF), 32'd0);
`ifdef BCD_LZB_EN
    check({tag, "_blank"}, 32'(oBLANK), 32'b1110);
`else
    check({tag, "_blank"}, 32'(oBLANK), 32'b0000);
`endif
  endtask

  initial begin
    int lat;
    int unsigned v;
    bit sawDone;

    repeat (3) @(posedge iCLK);
    #1;
    checkReset("rst");
    iRST_N = 1'b1;
    @(posedge iCLK); #1;

    runConv("zero", 0);
    runConv("v1234", 1234);
    runConv("v9999", 9999);
    runConv("v10000", 10000);
    runConv("vmax", 65535);

    // Start ignored while busy, then back-to-back start during the done cycle.
    launch(42);
    repeat (4) begin @(posedge iCLK); #1; end
    iBIN = 16'd7; iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    check("ign_busy", 32'(oBUSY), 32'd1);
    waitDone(lat);
    check("ign_lat", 32'(lat), 32'(LAT - 5));
    checkResult("v42", 42);
    launch(7);
    waitDone(lat);
    check("b2b_lat", 32'(lat), 32'(LAT));
    checkResult("v7", 7);
    @(posedge iCLK); #1;

    for (int i = 0; i < 24; i++) begin
      v = (i % 2 == 0) ? $urandom_range(0, 9999) : $urandom_range(0, 65535);
      if (i == 3) v = 10;
      if (i == 5) v = 100;
      runConv($sformatf("rnd%0d", i), v);
      repeat ($urandom_range(0, 2)) @(posedge iCLK);
      #0;
    end

    // Reset mid-conversion: abort, restore reset values, no done pulse.
    @(posedge iCLK); #1;
    launch(5555);
    repeat (6) begin @(posedge iCLK); #1; end
    iRST_N = 1'b0;
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    checkReset("midrst");
    sawDone = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge iCLK); #1;
      if (oDONE) sawDone = 1'b1;
    end
    check("midrst_nodone", 32'(sawDone), 32'd0);
    check("midrst_hold", 32'(oDIG), 32'd0);

    runConv("after", 5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
